slp_bool_train_ctrl: RTL and testbench

- Sequencer for one boolean-input single-layer perceptron neuron.
- Holds N_IN weights plus one bias in an internal register file. Time-multiplexes one signed accumulator and one shared slp_calc_bool_weight instance (W_CONF precision W_PREC) across all weights.
- Per sample it runs a serial inference pass. If train_en is set and the output mismatches the target, it runs a serial weight-update pass.
- Sits between the sample source / host and the neuron datapath.

---
 rtl/slp_bool_train_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_slp_bool_train_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slp_bool_train_ctrl.sv
// slp_bool_train_ctrl
//   Sequencer for one boolean-input single-layer perceptron neuron. Holds
//   N_IN weights plus a bias (index N_IN) and time-multiplexes one signed
//   accumulator and one weight-update unit across all entries. Per sample it
//   runs a serial inference pass and, when training is enabled and the output
//   disagrees with the target, a serial weight-update pass.
//
// Ports
//   clk       in   clock
//   reset     in   asynchronous active-high reset
//   start     in   begin a sample (accepted only in IDLE)
//   in_vec    in   boolean inputs, latched on an accepted start
//   target    in   desired output, latched on an accepted start
//   train_en  in   enable the update pass, latched on an accepted start
//   w_we      in   host weight write (IDLE only, start has priority)
//   w_addr    in   host write index, indices >= NW are ignored
//   w_wdata   in   host write data
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse at the end of a sample
//   y         out  neuron output of the last sample
//   mismatch  out  y != target of the last sample
//   weights   out  flattened register file, entry k at [k*W_PREC +: W_PREC]

// Weight-update rule: when in XNOR error is 1 the weight increments and
// saturates at +max; otherwise it decrements, but only while it is positive.
module slp_calc_bool_weight #(
  parameter int W_PREC = 8
) (
  input  logic              in_i,
  input  logic              error_i,
  input  logic [W_PREC-1:0] weight_i,
  output logic [W_PREC-1:0] weight_o
);

  localparam logic [W_PREC-1:0] WMAX = {1'b0, {(W_PREC-1){1'b1}}};

  always_comb begin
    weight_o = weight_i;
    if (in_i ~^ error_i) begin
      if (weight_i != WMAX) weight_o = weight_i + W_PREC'(1);
    end else if (!weight_i[W_PREC-1] && (weight_i != '0)) begin
      weight_o = weight_i - W_PREC'(1);
    end
  end

endmodule

module slp_bool_train_ctrl #(
  parameter int N_IN   = 8,
  parameter int W_PREC = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [N_IN-1:0]               in_vec,
  input  logic                          target,
  input  logic                          train_en,
  input  logic                          w_we,
  input  logic [$clog2(N_IN+1)-1:0]     w_addr,
  input  logic [W_PREC-1:0]             w_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          y,
  output logic                          mismatch,
  output logic [(N_IN+1)*W_PREC-1:0]    weights
);

  localparam int NW    = N_IN + 1;
  localparam int AW    = $clog2(NW);
  localparam int ACC_W = W_PREC + $clog2(N_IN + 1) + 1;
  localparam logic [AW-1:0] LAST = AW'(N_IN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUM,
    S_JUDGE,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [N_IN-1:0]          x_q, x_d;
  logic                     tgt_q, tgt_d;
  logic                     ten_q, ten_d;
  logic                     y_q, y_d;
  logic                     mis_q, mis_d;
  logic [W_PREC-1:0]        w_q [NW];

  logic                     wr_en;
  logic [AW-1:0]            wr_idx;
  logic [W_PREC-1:0]        wr_data;

  logic [NW-1:0]            x_ext;
  logic                     x_cur;
  logic [W_PREC-1:0]        w_cur;
  logic signed [ACC_W-1:0]  w_sext;
  logic [W_PREC-1:0]        w_upd;
  logic                     addr_ok;
  logic                     y_new;

  // Bias entry sees a constant 1 input.
  assign x_ext   = {1'b1, x_q};
  assign x_cur   = x_ext[idx_q];
  assign w_cur   = w_q[idx_q];
  assign w_sext  = ACC_W'(signed'(w_cur));
  assign addr_ok = ({1'b0, w_addr} < (AW+1)'(NW));

  slp_calc_bool_weight #(.W_PREC(W_PREC)) u_upd (
    .in_i     (x_cur),
    .error_i  (tgt_q),
    .weight_i (w_cur),
    .weight_o (w_upd)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    x_d     = x_q;
    tgt_d   = tgt_q;
    ten_d   = ten_q;
    y_d     = y_q;
    mis_d   = mis_q;
    wr_en   = 1'b0;
    wr_idx  = w_addr;
    wr_data = w_wdata;
    y_new   = ~acc_q[ACC_W-1];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = in_vec;
          tgt_d   = target;
          ten_d   = train_en;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_SUM;
        end else if (w_we && addr_ok) begin
          wr_en = 1'b1;
        end
      end
      S_SUM: begin
        // Bipolar input: a 0 bit subtracts the weight instead of skipping it.
        acc_d = x_cur ? (acc_q + w_sext) : (acc_q - w_sext);
        if (idx_q == LAST) state_d = S_JUDGE;
        else               idx_d   = idx_q + AW'(1);
      end
      S_JUDGE: begin
        y_d   = y_new;
        mis_d = (y_new != tgt_q);
        if ((y_new != tgt_q) && ten_q) begin
          idx_d   = '0;
          state_d = S_UPDATE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_UPDATE: begin
        wr_en   = 1'b1;
        wr_idx  = idx_q;
        wr_data = w_upd;
        if (idx_q == LAST) state_d = S_DONE;
        else               idx_d   = idx_q + AW'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      tgt_q   <= 1'b0;
      ten_q   <= 1'b0;
      y_q     <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      tgt_q   <= tgt_d;
      ten_q   <= ten_d;
      y_q     <= y_d;
      mis_q   <= mis_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (wr_en) begin
      w_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    weights = '0;
    for (int unsigned k = 0; k < NW; k++) weights[k*W_PREC +: W_PREC] = w_q[k];
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign y        = y_q;
  assign mismatch = mis_q;

endmodule

// File: tb/tb_slp_bool_train_ctrl.sv
// Testbench for slp_bool_train_ctrl (N_IN=2, W_PREC=4). A per-sample model
// computes the weighted sum, the output, the mismatch and the post-update
// weights from the neuron rules; a compare process checks every output on
// every falling edge against the cycle-by-cycle expectations derived from it.
module tb_slp_bool_train_ctrl;

  localparam int N_IN   = 2;
  localparam int W_PREC = 4;
  localparam int NW     = N_IN + 1;
  localparam int AW     = 2;
  localparam int WMAX   = 7;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic [N_IN-1:0]        in_vec = '0;
  logic                   target = 1'b0;
  logic                   train_en = 1'b0;
  logic                   w_we = 1'b0;
  logic [AW-1:0]          w_addr = '0;
  logic [W_PREC-1:0]      w_wdata = '0;
  logic                   busy, done, y, mismatch;
  logic [NW*W_PREC-1:0]   weights;

  int n_chk  = 0;
  int n_fail = 0;

  int   mw    [NW];
  int   exp_w [NW];
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;
  logic exp_y    = 1'b0;
  logic exp_mis  = 1'b0;
  bit   chk_en   = 1'b0;

  always #5 clk = ~clk;

  slp_bool_train_ctrl #(.N_IN(N_IN), .W_PREC(W_PREC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_vec   (in_vec),
    .target   (target),
    .train_en (train_en),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_wdata  (w_wdata),
    .busy     (busy),
    .done     (done),
    .y        (y),
    .mismatch (mismatch),
    .weights  (weights)
  );

  function automatic logic [NW*W_PREC-1:0] exp_vec();
    logic [NW*W_PREC-1:0] v;
    logic [31:0] t;
    v = '0;
    for (int k = 0; k < NW; k++) begin
      t = exp_w[k];
      v[k*W_PREC +: W_PREC] = t[W_PREC-1:0];
    end
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     32'(busy),     32'(exp_busy));
      check("done",     32'(done),     32'(exp_done));
      check("y",        32'(y),        32'(exp_y));
      check("mismatch", 32'(mismatch), 32'(exp_mis));
      check("weights",  32'(weights),  32'(exp_vec()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [W_PREC-1:0] d);
    w_we = 1'b1; w_addr = a; w_wdata = d;
    tick();
    w_we = 1'b0;
    if (int'(a) < NW) begin
      mw[a]    = int'($signed(d));
      exp_w[a] = mw[a];
    end
  endtask

  task automatic zero_model();
    for (int k = 0; k < NW; k++) begin
      mw[k] = 0;
      exp_w[k] = 0;
    end
    exp_busy = 1'b0; exp_done = 1'b0; exp_y = 1'b0; exp_mis = 1'b0;
  endtask

  // Runs one sample from IDLE. rst_at >= 1 asserts reset during that cycle
  // of the sample; collide drives a host write together with start.
  task automatic run_sample(input logic [N_IN-1:0] x, input logic t, input logic ten,
                            input int rst_at, input bit collide, output int done_cyc);
    int            s, lat;
    int            oldw [NW];
    int            neww [NW];
    logic [NW-1:0] xe;
    logic          yn, mn, upd;
    xe = {1'b1, x};
    s  = 0;
    for (int k = 0; k < NW; k++) s += xe[k] ? mw[k] : -mw[k];
    yn  = (s >= 0);
    mn  = (yn != t);
    upd = mn && ten;
    for (int k = 0; k < NW; k++) begin
      oldw[k] = mw[k];
      neww[k] = mw[k];
      if (upd) begin
        if (xe[k] == t) neww[k] = (mw[k] < WMAX) ? mw[k] + 1 : WMAX;
        else if (mw[k] > 0) neww[k] = mw[k] - 1;
      end
    end
    lat = upd ? 2*NW + 2 : NW + 2;
    done_cyc = -1;

    start = 1'b1; in_vec = x; target = t; train_en = ten;
    if (collide) begin
      w_we = 1'b1; w_addr = 2'($urandom_range(0, 2)); w_wdata = 4'($urandom);
    end
    tick();
    for (int c = 1; c <= lat; c++) begin
      // Pokes while busy must all be ignored.
      start    = ($urandom_range(0, 3) == 0);
      w_we     = ($urandom_range(0, 2) == 0);
      w_addr   = 2'($urandom);
      w_wdata  = 4'($urandom);
      in_vec   = 2'($urandom);
      target   = 1'($urandom);
      train_en = 1'($urandom);
      exp_busy = 1'b1;
      exp_done = (c == lat);
      if (c >= NW + 2) begin
        exp_y   = yn;
        exp_mis = mn;
      end
      for (int k = 0; k < NW; k++) exp_w[k] = (upd && (k < c - (NW + 2))) ? neww[k] : oldw[k];
      if (c == rst_at) begin
        start = 1'b0; w_we = 1'b0;
        reset = 1'b1;
        zero_model();
        tick();
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      if (done && done_cyc < 0) done_cyc = c;
      @(posedge clk);
      #1;
    end
    start = 1'b0; w_we = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0;
    for (int k = 0; k < NW; k++) mw[k] = neww[k];
  endtask

  initial begin
    int dc;
    zero_model();
    #1 chk_en = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state and out-of-range host write
    check("rst_weights", 32'(weights), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_y",       32'(y),       32'h0);
    host_write(2'd3, 4'hF);
    check("addr3_ignored", 32'(weights), 32'h0);

    // Zero weights, x=01, t=1: sum 0 -> y=1, no mismatch
    run_sample(2'b01, 1'b1, 1'b1, -1, 1'b0, dc);
    check("s2_done_cyc", 32'(dc), 32'd5);
    check("s2_y",        32'(y), 32'h1);
    check("s2_mis",      32'(mismatch), 32'h0);
    check("s2_weights",  32'(weights), 32'h0);

    // Zero weights, x=00, t=0: mismatch, w0/w1 -> 1, bias held at 0
    run_sample(2'b00, 1'b0, 1'b1, -1, 1'b0, dc);
    check("s3_done_cyc", 32'(dc), 32'd8);
    check("s3_mis",      32'(mismatch), 32'h1);
    check("s3_weights",  32'(weights), 32'h011);

    // w0=7, w1=0, bias=-8, x=11, t=1: acc=-1, y=0
    host_write(2'd0, 4'h7);
    host_write(2'd1, 4'h0);
    host_write(2'd2, 4'h8);
    run_sample(2'b11, 1'b1, 1'b1, -1, 1'b0, dc);
    check("s4_done_cyc",  32'(dc), 32'd8);
    check("s4_y",         32'(y), 32'h0);
    check("s4_weights",   32'(weights), 32'h917);
    check("s4_model_bias", 32'(mw[2]), 32'(-7));

    // Training disabled, plus a start/w_we collision
    host_write(2'd0, 4'h0);
    host_write(2'd1, 4'h0);
    host_write(2'd2, 4'h0);
    run_sample(2'b00, 1'b0, 1'b0, -1, 1'b1, dc);
    check("s5_done_cyc", 32'(dc), 32'd5);
    check("s5_mis",      32'(mismatch), 32'h1);
    check("s5_weights",  32'(weights), 32'h0);

    // Reset mid-UPDATE, then a clean rerun
    run_sample(2'b00, 1'b0, 1'b1, 6, 1'b0, dc);
    check("s6_busy",    32'(busy), 32'h0);
    check("s6_weights", 32'(weights), 32'h0);
    run_sample(2'b00, 1'b0, 1'b1, -1, 1'b0, dc);
    check("s6_done_cyc", 32'(dc), 32'd8);
    check("s6_weights",  32'(weights), 32'h011);

    repeat (80) begin
      repeat ($urandom_range(0, 3)) host_write(2'($urandom), 4'($urandom));
      run_sample(2'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : -1,
                 ($urandom_range(0, 3) == 0), dc);
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
